aes_kexp_dec: RTL and testbench
===============================

// Module: aes_kexp_dec
// PURPOSE
// - Sequential key schedule for the decryption datapath.
// - Expands the cipher key one 32-bit word per clock into a local word store.
// - Then streams 128-bit round keys in reverse order (round Nr down to 0) over a valid/ready handshake.
// - Optionally applies InvMixColumns to rounds 1..Nr-1, producing keys for the equivalent inverse cipher.
// - Sits between key load and the inverse-cipher round engine.
// PARAMETERS
// - INV_MIX  0  1: apply InvMixColumns to the words of rounds 1..Nr-1; 0: raw round keys.
// - Nk, Nb, Nr come from aes_const; W = Nb*(Nr+1) total words.
// PORTS
// - clock   in   1            Single clock; all state updates on its rising edge.
// - reset   in   1            Synchronous, active-high.
// - Start   in   1            Begin a schedule; sampled only in IDLE.
// - Key     in   8x(4*Nk)     Cipher key bytes, Key[0] = MSB of word 0; sampled with Start.
// - RCon    in   8x16         Round constant table.
// - SBox    in   8x256        Forward S-box table.
// - Busy    out  1            High from the cycle after accepted Start until the last round-key transfer.
// - RValid  out  1            Round key valid.
// - RReady  in   1            Consumer accepts round key.
// - RKey    out  32x4         Round key, RKey[0] = word 4r.
// - RRound  out  4            Round index r of RKey.
// - RLast   out  1            High with RValid when r == 0.
// BEHAVIOUR
// - Reset values:
//   - Busy, RValid, RLast = 0; RKey = 0; RRound = 0.
//   - FSM = IDLE; word counter = 0. The word store need not be cleared.
// - FSM IDLE:
//   - Start=1 writes w[0..Nk-1] = Key words at that edge.
//   - Goes to EXPAND; Busy=1 from the next cycle.
// - FSM EXPAND:
//   - One word per edge, i = Nk..W-1. For each i:
//     - i%Nk==0:            w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {RCon[i/Nk],24'h0}
//     - Nk>6 && i%Nk==4:    w[i] = w[i-Nk] ^ SubWord(w[i-1])
//     - otherwise:          w[i] = w[i-Nk] ^ w[i-1]
//     - RotWord = rotate left one byte.
//   - The edge writing w[W-1] loads RKey = w[4Nr..4Nr+3] and RRound = Nr, sets RValid=1, and enters STREAM.
//   - Latency: RValid is first high (W-Nk)+1 edges after the Start edge (AES-128: 41 edges).
// - FSM STREAM:
//   - A transfer occurs on an edge with RValid && RReady.
//   - RKey, RRound and RLast are registered and held stable while RValid && !RReady.
//   - On a transfer with r>0: load round r-1 at that edge. No bubble: back-to-back RReady gives one key per cycle.
//   - On a transfer with r==0: RValid, RLast, Busy -> 0 and FSM -> IDLE at the same edge.
// - INV_MIX=1: each word of rounds 1..Nr-1 passes through InvMixColumns before the RKey register. Rounds 0 and Nr are untouched.
// - Start while not IDLE: ignored, no effect on the schedule.
// - Start is accepted again in the cycle after the final transfer.
// - reset mid-EXPAND or mid-STREAM: the schedule is aborted and all outputs take their reset values at that edge.
// - RReady while RValid=0: ignored.
// - Key and SBox changes after the Start edge: no effect except via already-stored words.
//   - SBox and RCon must stay stable throughout EXPAND.
// STRUCTURE
// - aes_const: Nk, Nb, Nr.
// - aes_wire: FSM state enum typedef (IDLE, EXPAND, STREAM).
// - Word store: W x 32 register array.
// - Word counter: clog2(W) bits. Round counter: 4 bits.
// - One sub-module: aes_inv_mixcol, a combinational single-column InvMixColumns (GF(2^8), poly 0x11B).
//   - Four instances on the read path, bypassed for r==0, r==Nr or INV_MIX=0.
// TESTING
// - AES-128 with key 2b7e1516 28aed2a6 abf71588 09cf4f3c, RReady=1, INV_MIX=0:
//   - RValid after 41 edges.
//   - First key: r=10, d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
//   - Then 11 consecutive transfers.
//   - r=1 key: a0fafe17 88542cb1 23a33939 2a6c7605.
//   - r=0 key equals the cipher key, with RLast=1.
// - AES-256 (Nk=8) with key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
//   - First key: r=14, fe4890d1 e6188d0b 046df344 706c631e.
//   - RValid after W-Nk+1 = 53 edges.
// - Backpressure: hold RReady=0 for 5 cycles at r=7, then release.
//   - RKey and RRound are stable throughout; r=6 appears on the edge after release.
//   - Randomised RReady: the sequence is unchanged.
// - Start pulses during EXPAND and STREAM: ignored, the key sequence is bit-identical.
//   - Start on the cycle after RLast's transfer restarts the schedule.
// - reset asserted at EXPAND word 20 and at STREAM r=5:
//   - All outputs are 0 at the next edge.
//   - A subsequent Start yields the full correct sequence.
// - INV_MIX=1: all 11 keys match a software reference model (FIPS-197 equivalent inverse cipher).
//   - r=10 and r=0 are identical to the INV_MIX=0 run.

Source files
------------

// File: rtl/aes_kexp_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_kexp_dec_pkg
//  Description : Shared constants, FSM state encoding and byte/word helpers
//                for the decryption key schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_kexp_dec_pkg;

    // Block width in 32-bit words and the default key length (AES-128).
    localparam int C_AES_NB = 4;
    localparam int C_AES_NK = 4;

    // Schedule controller states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_STREAM = 2'd2
    } kexp_state_t;

    // Number of rounds for a given key length in words.
    function automatic int aes_nr(input int nk);
        return nk + 6;
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Apply the S-box to each byte of a word.
    function automatic logic [31:0] sub_word(input logic [31:0] w,
                                             input logic [0:255][7:0] sbox);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_mixcol.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_mixcol
//  Description : Combinational InvMixColumns on a single 32-bit column,
//                byte 0 in bits [31:24].
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_mixcol
    import aes_kexp_dec_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    logic [7:0] w_m9 [4];
    logic [7:0] w_mb [4];
    logic [7:0] w_md [4];
    logic [7:0] w_me [4];

    // Per-byte multiples 9, 11, 13 and 14 built from repeated xtime.
    for (genvar k = 0; k < 4; k++) begin : g_byte
        logic [7:0] w_a;
        logic [7:0] w_x2;
        logic [7:0] w_x4;
        logic [7:0] w_x8;
        assign w_a     = col[31-8*k -: 8];
        assign w_x2    = xtime(w_a);
        assign w_x4    = xtime(w_x2);
        assign w_x8    = xtime(w_x4);
        assign w_m9[k] = w_x8 ^ w_a;
        assign w_mb[k] = w_x8 ^ w_x2 ^ w_a;
        assign w_md[k] = w_x8 ^ w_x4 ^ w_a;
        assign w_me[k] = w_x8 ^ w_x4 ^ w_x2;
    end

    assign mixed[31:24] = w_me[0] ^ w_mb[1] ^ w_md[2] ^ w_m9[3];
    assign mixed[23:16] = w_m9[0] ^ w_me[1] ^ w_mb[2] ^ w_md[3];
    assign mixed[15:8]  = w_md[0] ^ w_m9[1] ^ w_me[2] ^ w_mb[3];
    assign mixed[7:0]   = w_mb[0] ^ w_md[1] ^ w_m9[2] ^ w_me[3];

endmodule
`default_nettype wire

// File: rtl/aes_kexp_dec.sv
`default_nettype none
// ============================================================================
//  Module      : aes_kexp_dec
//  Description : Sequential AES key expansion (one word per clock) followed
//                by round-key streaming from round Nr down to 0, with
//                optional InvMixColumns on the middle rounds.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_kexp_dec
    import aes_kexp_dec_pkg::*;
#(
    parameter int NK      = C_AES_NK,
    parameter bit INV_MIX = 1'b0
)(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    Start,
    input  logic [0:4*NK-1][7:0]    Key,
    input  logic [0:15][7:0]        RCon,
    input  logic [0:255][7:0]       SBox,
    output logic                    Busy,
    output logic                    RValid,
    input  logic                    RReady,
    output logic [0:3][31:0]        RKey,
    output logic [3:0]              RRound,
    output logic                    RLast
);

    localparam int C_NR = aes_nr(NK);
    localparam int C_NW = C_AES_NB * (C_NR + 1);
    localparam int C_CW = $clog2(C_NW);

    kexp_state_t        r_state;
    kexp_state_t        w_state_nxt;
    logic [31:0]        r_w [C_NW];
    logic [C_CW-1:0]    r_cnt;

    logic               w_start_acc;
    logic               w_exp_last;
    logic               w_xfer;
    logic               w_load;
    logic [31:0]        w_new;
    logic [3:0]         w_rd_round;
    logic [C_CW-1:0]    w_base;
    logic               w_bypass;
    logic [31:0]        w_raw [4];
    logic [31:0]        w_mix [4];
    logic [0:3][31:0]   w_key;

    // Controller state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_exp_last  = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (r_cnt == C_CW'(C_NW - 1)) begin
                    w_exp_last  = 1'b1;
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (RValid && RReady) begin
                    w_xfer = 1'b1;
                    if (RRound == 4'd0) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next schedule word from w[i-Nk] and w[i-1].
    always_comb begin
        logic [31:0] v_prev;
        logic [31:0] v_old;
        int          v_mod;
        v_prev = r_w[r_cnt - C_CW'(1)];
        v_old  = r_w[r_cnt - C_CW'(NK)];
        v_mod  = int'(r_cnt) % NK;
        if (v_mod == 0) begin
            w_new = v_old ^ sub_word({v_prev[23:0], v_prev[31:24]}, SBox)
                  ^ {RCon[4'(int'(r_cnt) / NK)], 24'h0};
        end else if (NK > 6 && v_mod == 4) begin
            w_new = v_old ^ sub_word(v_prev, SBox);
        end else begin
            w_new = v_old ^ v_prev;
        end
    end

    // Word store: key words on Start, one expanded word per EXPAND cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (w_start_acc) begin
                for (int k = 0; k < NK; k++) begin
                    r_w[k] <= Key[4*k +: 4];
                end
            end
            if (r_state == ST_EXPAND) begin
                r_w[r_cnt] <= w_new;
            end
        end
    end

    // Round-key read path; the last expand cycle still has w[W-1] in flight.
    assign w_load     = w_exp_last || (w_xfer && RRound != 4'd0);
    assign w_rd_round = (r_state == ST_EXPAND) ? 4'(C_NR) : RRound - 4'd1;
    assign w_base     = C_CW'({w_rd_round, 2'b00});
    assign w_bypass   = !INV_MIX || w_rd_round == 4'd0 || w_rd_round == 4'(C_NR);

    // Gather the four words of the round being loaded.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_raw[k] = r_w[w_base + C_CW'(k)];
        end
        if (r_state == ST_EXPAND) begin
            w_raw[3] = w_new;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_imc
        aes_inv_mixcol u_imc (
            .col   (w_raw[k]),
            .mixed (w_mix[k])
        );
        assign w_key[k] = w_bypass ? w_raw[k] : w_mix[k];
    end

    // Word counter, Busy and the registered round-key output stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt  <= '0;
            Busy   <= 1'b0;
            RValid <= 1'b0;
            RLast  <= 1'b0;
            RKey   <= '0;
            RRound <= '0;
        end else begin
            if (w_start_acc) begin
                r_cnt <= C_CW'(NK);
                Busy  <= 1'b1;
            end
            if (r_state == ST_EXPAND) begin
                r_cnt <= r_cnt + C_CW'(1);
            end
            if (w_load) begin
                RKey   <= w_key;
                RRound <= w_rd_round;
                RValid <= 1'b1;
                RLast  <= (w_rd_round == 4'd0);
            end
            if (w_xfer && RRound == 4'd0) begin
                RValid <= 1'b0;
                RLast  <= 1'b0;
                Busy   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_kexp_dec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_kexp_dec
//  Description : Directed self-checking bench for the decryption key
//                schedule (AES-128, AES-256, InvMixColumns variant).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aes_kexp_dec;

    localparam logic [127:0] K128    = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [255:0] K256    = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
    localparam logic [127:0] R10_128 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] R1_128  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] R14_256 = 128'hfe4890d1_e6188d0b_046df344_706c631e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic go;
    logic ready;
    int   sel;
    int   checks;
    int   fails;

    logic [0:15][7:0]  rcon_t;
    logic [0:255][7:0] sbox_t;
    logic [0:15][7:0]  key128;
    logic [0:31][7:0]  key256;

    logic busy_a, valid_a, last_a, busy_b, valid_b, last_b, busy_m, valid_m, last_m;
    logic [0:3][31:0] rkey_a, rkey_b, rkey_m;
    logic [3:0] round_a, round_b, round_m;

    logic obs_busy, obs_valid, obs_last;
    logic [127:0] obs_key;
    logic [3:0] obs_round;

    logic [31:0]  m_w [60];
    logic [127:0] got [15];

    aes_kexp_dec #(.NK(4), .INV_MIX(1'b0)) dut_a (
        .clock(clk), .reset(rst), .Start(go && sel == 0), .Key(key128),
        .RCon(rcon_t), .SBox(sbox_t), .Busy(busy_a), .RValid(valid_a),
        .RReady(ready), .RKey(rkey_a), .RRound(round_a), .RLast(last_a));

    aes_kexp_dec #(.NK(8), .INV_MIX(1'b0)) dut_b (
        .clock(clk), .reset(rst), .Start(go && sel == 1), .Key(key256),
        .RCon(rcon_t), .SBox(sbox_t), .Busy(busy_b), .RValid(valid_b),
        .RReady(ready), .RKey(rkey_b), .RRound(round_b), .RLast(last_b));

    aes_kexp_dec #(.NK(4), .INV_MIX(1'b1)) dut_m (
        .clock(clk), .reset(rst), .Start(go && sel == 2), .Key(key128),
        .RCon(rcon_t), .SBox(sbox_t), .Busy(busy_m), .RValid(valid_m),
        .RReady(ready), .RKey(rkey_m), .RRound(round_m), .RLast(last_m));

    // Route the selected instance to the common observation signals.
    always_comb begin
        obs_busy = busy_m; obs_valid = valid_m; obs_last = last_m;
        obs_key = rkey_m; obs_round = round_m;
        if (sel == 0) begin
            obs_busy = busy_a; obs_valid = valid_a; obs_last = last_a;
            obs_key = rkey_a; obs_round = round_a;
        end else if (sel == 1) begin
            obs_busy = busy_b; obs_valid = valid_b; obs_last = last_b;
            obs_key = rkey_b; obs_round = round_b;
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [31:0] invmix_w(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24]; a1 = w[23:16]; a2 = w[15:8]; a3 = w[7:0];
        return {gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
                gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
                gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
                gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
    endfunction

    function automatic logic [127:0] exp_key(input int r, input int nr, input bit mix);
        logic [31:0] k [4];
        for (int j = 0; j < 4; j++) begin
            k[j] = m_w[4*r + j];
            if (mix && r != 0 && r != nr) k[j] = invmix_w(k[j]);
        end
        return {k[0], k[1], k[2], k[3]};
    endfunction

    // Build the forward S-box from GF inverse and affine transform.
    task automatic build_sbox();
        logic [7:0] inv, t, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            t = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                t = {t[6:0], t[7]};
                s = s ^ t;
            end
            sbox_t[x] = s ^ 8'h63;
        end
    endtask

    // Reference key expansion (FIPS-197) into m_w.
    task automatic model_expand(input int nk, input logic [255:0] key);
        logic [31:0] t;
        for (int i = 0; i < 4*(nk+7); i++) begin
            if (i < nk) begin
                m_w[i] = key[255-32*i -: 32];
            end else begin
                t = m_w[i-1];
                if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk], 24'h0};
                else if (nk > 6 && i % nk == 4) t = subw(t);
                m_w[i] = m_w[i-nk] ^ t;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_and_wait(input string tag, input int exp_lat, input int pulse_n);
        int n;
        go = 1'b1;
        tick();
        go = 1'b0;
        n = 1;
        checks++;
        if (obs_busy !== 1'b1) begin
            fails++;
            $display("FAIL %s_busy: got %b expected 1", tag, obs_busy);
        end
        while (obs_valid !== 1'b1 && n < 200) begin
            go = (n == pulse_n);
            tick();
            n++;
        end
        go = 1'b0;
        checks++;
        if (n !== exp_lat) begin
            fails++;
            $display("FAIL %s_latency: got %0d edges expected %0d", tag, n, exp_lat);
        end
    endtask

    // mode 0: RReady held high; mode 2: stall 5 cycles at r=7, then random.
    task automatic check_stream(input string tag, input int nr, input bit mix,
                                input int mode, input int pulse_r);
        int r, cyc, held;
        logic [127:0] e;
        r = nr; cyc = 0; held = 0;
        while (r >= 0 && cyc < 300) begin
            e = exp_key(r, nr, mix);
            checks++;
            if (obs_valid !== 1'b1 || obs_round !== 4'(r) || obs_key !== e || obs_last !== (r == 0)) begin
                fails++;
                $display("FAIL %s_r%0d: got v=%b r=%0d key=%h last=%b expected v=1 r=%0d key=%h last=%b",
                         tag, r, obs_valid, obs_round, obs_key, obs_last, r, e, (r == 0));
            end
            got[r] = obs_key;
            if (mode == 2 && r == 7 && held < 5) begin
                ready = 1'b0;
                held++;
            end else if (mode == 2 && r < 7) begin
                ready = 1'($urandom_range(0, 1));
            end else begin
                ready = 1'b1;
            end
            go = (r == pulse_r);
            tick();
            cyc++;
            if (ready) r--;
        end
        go = 1'b0;
        ready = 1'b0;
        checks++;
        if (cyc >= 300 || obs_valid !== 1'b0 || obs_busy !== 1'b0 || obs_last !== 1'b0) begin
            fails++;
            $display("FAIL %s_end: got cycles=%0d v=%b busy=%b last=%b expected v=0 busy=0 last=0",
                     tag, cyc, obs_valid, obs_busy, obs_last);
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({obs_busy, obs_valid, obs_last, obs_round, obs_key} !== '0) begin
            fails++;
            $display("FAIL %s_zero: got busy=%b v=%b last=%b r=%0d key=%h expected all 0",
                     tag, obs_busy, obs_valid, obs_last, obs_round, obs_key);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_zero($sformatf("reset_dut%0d", s));
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_aes128();
        sel = 0;
        model_expand(4, {K128, 128'h0});
        start_and_wait("aes128", 41, 0);
        check_stream("aes128", 10, 1'b0, 0, -1);
        checks++;
        if (got[10] !== R10_128) begin fails++; $display("FAIL aes128_r10_const: got %h expected %h", got[10], R10_128); end
        checks++;
        if (got[1] !== R1_128) begin fails++; $display("FAIL aes128_r1_const: got %h expected %h", got[1], R1_128); end
        checks++;
        if (got[0] !== K128) begin fails++; $display("FAIL aes128_r0_const: got %h expected %h", got[0], K128); end
    endtask

    task automatic test_aes256();
        sel = 1;
        model_expand(8, K256);
        start_and_wait("aes256", 53, 0);
        check_stream("aes256", 14, 1'b0, 0, -1);
        checks++;
        if (got[14] !== R14_256) begin fails++; $display("FAIL aes256_r14_const: got %h expected %h", got[14], R14_256); end
        model_expand(4, {K128, 128'h0});
    endtask

    task automatic test_backpressure();
        sel = 0;
        start_and_wait("bp", 41, 0);
        check_stream("bp", 10, 1'b0, 2, -1);
    endtask

    task automatic test_start_ignored();
        sel = 0;
        start_and_wait("ign", 41, 20);
        check_stream("ign", 10, 1'b0, 0, 5);
        start_and_wait("restart", 41, 0);
        check_stream("restart", 10, 1'b0, 0, -1);
    endtask

    task automatic test_reset_abort();
        int c;
        sel = 0;
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (16) tick();
        checks++;
        if (obs_busy !== 1'b1) begin fails++; $display("FAIL abort_exp_busy: got %b expected 1", obs_busy); end
        rst = 1'b1;
        tick();
        check_zero("abort_exp");
        rst = 1'b0;
        start_and_wait("rerun_exp", 41, 0);
        check_stream("rerun_exp", 10, 1'b0, 0, -1);
        start_and_wait("abort_st", 41, 0);
        ready = 1'b1;
        c = 0;
        while (obs_round !== 4'd5 && c < 50) begin
            tick();
            c++;
        end
        rst = 1'b1;
        ready = 1'b0;
        tick();
        check_zero("abort_st");
        rst = 1'b0;
        start_and_wait("rerun_st", 41, 0);
        check_stream("rerun_st", 10, 1'b0, 0, -1);
    endtask

    task automatic test_inv_mix();
        sel = 2;
        start_and_wait("imc", 41, 0);
        check_stream("imc", 10, 1'b1, 0, -1);
        checks++;
        if (got[10] !== R10_128) begin fails++; $display("FAIL imc_r10_raw: got %h expected %h", got[10], R10_128); end
        checks++;
        if (got[0] !== K128) begin fails++; $display("FAIL imc_r0_raw: got %h expected %h", got[0], K128); end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Test sequence.
    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        go     = 1'b0;
        ready  = 1'b0;
        sel    = 0;
        rcon_t = {8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                  8'h80, 8'h1b, 8'h36, 8'h6c, 8'hd8, 8'hab, 8'h4d, 8'h9a};
        key128 = K128;
        key256 = K256;
        build_sbox();
        test_reset();
        test_aes128();
        test_aes256();
        test_backpressure();
        test_start_ignored();
        test_reset_abort();
        test_inv_mix();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
